// File: rtl/dmem_pkg.sv
// Shared types, widths and the byte-mask helper for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Expand a byte-enable vector into a 32-bit data mask.
    function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = {DATA_W{1'b0}};
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port word array with per-byte write enables and a masked, registered read port.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [BE_W-1:0]   i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rmask,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Array storage: deliberately has no reset so contents survive RSTn.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register: holds between reads; a zero mask gives a cleared word.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rdata <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr] & i_rmask;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/BUSY/RESP handshake with programmable latency.
// Optional access counters are enabled by defining DMEM_ACCESS_CNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              D_MEM_CSN,
    input  logic              D_MEM_WEN,
    input  logic [BE_W-1:0]   D_MEM_BE,
    input  logic [31:0]       D_MEM_ADDR,
    input  logic [DATA_W-1:0] D_MEM_DI,
    output logic [DATA_W-1:0] D_MEM_DOUT,
    output logic              D_MEM_RDY,
    output logic              D_MEM_ERR
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       NUM_RD,
    output logic [31:0]       NUM_WR
`endif
);

    localparam int               CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam bit               ZERO_LAT = (LATENCY == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : {CNT_W{1'b0}};

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic              r_wen;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_di;
    logic              r_rdy;
    logic              r_err;

    logic              w_accept;
    logic              w_enter_resp;
    logic [31:0]       w_acc_addr;
    logic              w_acc_wen;
    logic [BE_W-1:0]   w_acc_be;
    logic [DATA_W-1:0] w_acc_di;
    logic              w_oor;
    logic [ADDR_W-1:0] w_idx;
    logic [BE_W-1:0]   w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_rmask;
    logic [DATA_W-1:0] w_rdata;

    // Access selection: with zero latency the accepting edge is also the access
    // edge, so the live request is used instead of the not-yet-latched copy.
    always_comb begin
        w_accept = (r_state == IDLE) && !D_MEM_CSN;
        if (ZERO_LAT && (r_state == IDLE)) begin
            w_acc_addr   = D_MEM_ADDR;
            w_acc_wen    = D_MEM_WEN;
            w_acc_be     = D_MEM_BE;
            w_acc_di     = D_MEM_DI;
            w_enter_resp = w_accept;
        end else begin
            w_acc_addr   = r_addr;
            w_acc_wen    = r_wen;
            w_acc_be     = r_be;
            w_acc_di     = r_di;
            w_enter_resp = !ZERO_LAT && (r_state == BUSY) && (r_cnt == {CNT_W{1'b0}});
        end
    end

    // Range check, array index and RAM strobes for the access edge.
    always_comb begin
        w_oor = (w_acc_addr >> (ADDR_W + 2)) != 32'd0;
        w_idx = w_acc_addr[ADDR_W+1:2];
        if (w_enter_resp && !w_acc_wen && !w_oor) begin
            w_ram_we = w_acc_be;
        end else begin
            w_ram_we = {BE_W{1'b0}};
        end
        w_ram_re = w_enter_resp && w_acc_wen;
        if (w_oor) begin
            w_rmask = {DATA_W{1'b0}};
        end else begin
            w_rmask = be_mask(w_acc_be);
        end
    end

    dmem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_idx),
        .i_wdata (w_acc_di),
        .i_rmask (w_rmask),
        .o_rdata (w_rdata)
    );

    // Handshake FSM with latency counter, request latch and registered RDY/ERR.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_addr  <= 32'd0;
            r_wen   <= 1'b1;
            r_be    <= {BE_W{1'b0}};
            r_di    <= {DATA_W{1'b0}};
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdy <= 1'b0;
                    r_err <= 1'b0;
                    if (w_accept) begin
                        r_addr <= D_MEM_ADDR;
                        r_wen  <= D_MEM_WEN;
                        r_be   <= D_MEM_BE;
                        r_di   <= D_MEM_DI;
                        if (ZERO_LAT) begin
                            r_state <= RESP;
                            r_rdy   <= 1'b1;
                            r_err   <= w_oor;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_LOAD;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (w_enter_resp) begin
                        r_state <= RESP;
                        r_rdy   <= 1'b1;
                        r_err   <= w_oor;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign D_MEM_DOUT = w_rdata;
    assign D_MEM_RDY  = r_rdy;
    assign D_MEM_ERR  = r_err;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] r_num_rd;
    logic [31:0] r_num_wr;

    // In-range access counters, bumped on the access edge; they wrap naturally.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_num_rd <= 32'd0;
            r_num_wr <= 32'd0;
        end else if (w_enter_resp && !w_oor) begin
            if (w_acc_wen) begin
                r_num_rd <= r_num_rd + 32'd1;
            end else begin
                r_num_wr <= r_num_wr + 32'd1;
            end
        end else begin
            r_num_rd <= r_num_rd;
            r_num_wr <= r_num_wr;
        end
    end

    assign NUM_RD = r_num_rd;
    assign NUM_WR = r_num_wr;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-memory port driven by the multicycle core controller.
- Samples an active-low chip select, an active-low write enable, byte enables, a byte address and write data.
- Performs the access against an internal word array after a programmable latency.
- Signals completion with a one-cycle ready pulse, plus an error flag for out-of-range addresses.

Parameters:
ADDR_W, 10, word-index width; array depth = 2**ADDR_W words of 32 bits
LATENCY, 2, number of BUSY cycles between request acceptance and response (0 allowed)

Ports:
CLK  input  1  clock, rising edge active
RSTn  input  1  reset, asynchronous, active-low
D_MEM_CSN  input  1  chip select, active-low; request present when 0
D_MEM_WEN  input  1  0 = write, 1 = read
D_MEM_BE  input  4  byte enables; bit i covers data bits [8i+7:8i]
D_MEM_ADDR  input  32  byte address
D_MEM_DI  input  32  write data
D_MEM_DOUT  output  32  read data, valid while D_MEM_RDY=1
D_MEM_RDY  output  1  one-cycle completion pulse
D_MEM_ERR  output  1  out-of-range flag, valid while D_MEM_RDY=1

Behaviour:
- Interface: one clock, CLK; reset RSTn is asynchronous and active-low.
- Reset state: FSM in IDLE; D_MEM_DOUT=0, D_MEM_RDY=0, D_MEM_ERR=0, latency counter=0.
- Array contents are not cleared by reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On a rising edge with D_MEM_CSN=0, latch ADDR, WEN, BE and DI.
  - Go to BUSY with cnt=LATENCY-1 when LATENCY>0; go directly to RESP when LATENCY=0.
  - With D_MEM_CSN=1, stay in IDLE.
- BUSY:
  - Decrement cnt each cycle.
  - When cnt=0, the next edge enters RESP.
  - Inputs are ignored while in BUSY.
- Edge entering RESP:
  - Write: for each BE bit set, write the latched byte to mem[idx].
  - Read: load D_MEM_DOUT with mem[idx]; bytes whose BE bit is 0 read as 0x00.
  - idx = latched ADDR[ADDR_W+1:2]. ADDR[1:0] is ignored (accesses are word-aligned by contract).
- RESP:
  - D_MEM_RDY=1 for exactly this cycle.
  - The next edge returns to IDLE unconditionally, and D_MEM_RDY drops to 0.
  - Inputs are ignored in RESP.
- Latency: D_MEM_RDY is high in the cycle following edge t0+LATENCY, where t0 is the accepting edge.
- Back-to-back: the initiator holds its request until D_MEM_RDY.
  - If D_MEM_CSN is still 0 in the IDLE cycle after RESP, that is a new access.
  - Minimum request spacing is LATENCY+2 cycles.
- Out of range: latched ADDR[31:ADDR_W+2] != 0.
  - Write is suppressed, D_MEM_DOUT=0 and D_MEM_ERR=1 in RESP.
  - D_MEM_ERR=0 otherwise.
- BE=0000: a read returns 0 and a write leaves the array unchanged; RDY is still pulsed.
- D_MEM_DOUT holds its value after RESP until the next read completes.
  - An out-of-range read or a reset clears it to 0.
- Reset mid-operation (BUSY or RESP): the pending access is dropped (no write commits), and outputs go to their reset values immediately.
- Latency counter width: $clog2(LATENCY+1), minimum 1 bit.

Optional Feature:
- Macro: DMEM_ACCESS_CNT_EN.
- When defined:
  - Adds outputs NUM_RD[31:0] and NUM_WR[31:0], reset to 0.
  - Each increments by 1 on the edge entering RESP for an in-range read or write respectively.
  - Out-of-range accesses are not counted; the counters wrap at 2**32.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, BUSY, RESP}
  - constants DATA_W=32, BE_W=4
  - function be_mask(be) returning the 32-bit byte mask
- Sub-module dmem_byte_ram: synchronous 2**ADDR_W x 32 array, one port, per-byte write enable, registered read.
- The FSM, latency counter, range check and optional counters live in dmem_responder.

Test Plan:
1. LATENCY=2: write ADDR=0x10, BE=1111, DI=0xDEADBEEF, CSN low at t0 -> RDY=1 only in the cycle after edge t0+2, ERR=0. Then a read of 0x10 -> DOUT=0xDEADBEEF with RDY.
2. Partial write: BE=0101, DI=0x11223344 to a word holding 0xDEADBEEF -> read with BE=1111 returns 0xDE22BE44. Read with BE=0011 returns 0x0000BE44.
3. Out of range: ADDR=0x00001000 with ADDR_W=10, write then read -> ERR=1, DOUT=0, array unchanged. With DMEM_ACCESS_CNT_EN, NUM_WR/NUM_RD are unchanged.
4. CSN held low for 6 cycles with LATENCY=2 -> two accesses. RDY pulses after edges t0+2 and t0+6, and never two consecutive RDY cycles.
5. Reset pulse on RSTn during BUSY of a write to 0x20 -> RDY, ERR and DOUT go to 0 asynchronously. A later read of 0x20 returns the prior value.
6. LATENCY=0: read accepted at edge t0 -> RDY high in the cycle immediately after t0. Three reads and two writes give NUM_RD=3, NUM_WR=2 (macro defined).
